// File: rtl/ram.sv
// 64 x 8 random-access memory with asynchronous active-low clear of the whole array.
// Read path is combinational by default; define RAM_REG_OUT_EN for a registered, write-first read.
module ram (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] Data,
    input  logic [5:0] Addr,
    input  logic       we,
    output logic [7:0] X
);

    logic [7:0] mem [0:63];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 64; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[Addr] <= Data;
        end
    end

`ifdef RAM_REG_OUT_EN
    logic [7:0] xreg;

    // Addr is shared by both ports, so a write always targets the word being read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xreg <= '0;
        end else if (we) begin
            xreg <= Data;
        end else begin
            xreg <= mem[Addr];
        end
    end

    assign X = xreg;
`else
    assign X = mem[Addr];
`endif

endmodule

// File: tb/tb_ram.sv
// Directed, table-driven self-checking bench for the 64 x 8 ram.
module tb_ram;

    logic       clk;
    logic       rst_n;
    logic [7:0] Data;
    logic [5:0] Addr;
    logic       we;
    logic [7:0] X;

    int unsigned passed;
    int unsigned total;

    ram dut (
        .clk  (clk),
        .rst_n(rst_n),
        .Data (Data),
        .Addr (Addr),
        .we   (we),
        .X    (X)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [5:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [15];
    vec_t post [5];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got === want) begin
            passed++;
        end else begin
            $display("FAIL %s: X=%h expected %h", name, got, want);
        end
    endtask

    // Drive at the falling edge, let one rising edge happen, sample 1 time unit later.
    task automatic apply(input string name, input vec_t v);
        @(negedge clk);
        we   = v.we;
        Addr = v.addr;
        Data = v.data;
        @(posedge clk);
        #1;
        check(name, X, v.exp);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        we     = 1'b0;
        Addr   = '0;
        Data   = '0;

        vecs[0]  = '{1'b0, 6'd0,  8'h00, 8'h00};
        vecs[1]  = '{1'b0, 6'd5,  8'h00, 8'h00};
        vecs[2]  = '{1'b0, 6'd10, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 6'd63, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 6'd5,  8'hA5, 8'hA5};
        vecs[5]  = '{1'b0, 6'd5,  8'hFF, 8'hA5};
        vecs[6]  = '{1'b1, 6'd10, 8'h3C, 8'h3C};
        vecs[7]  = '{1'b0, 6'd10, 8'h00, 8'h3C};
        vecs[8]  = '{1'b0, 6'd5,  8'hFF, 8'hA5};
        vecs[9]  = '{1'b0, 6'd5,  8'hFF, 8'hA5};
        vecs[10] = '{1'b1, 6'd0,  8'h11, 8'h11};
        vecs[11] = '{1'b1, 6'd63, 8'h22, 8'h22};
        vecs[12] = '{1'b0, 6'd0,  8'h00, 8'h11};
        vecs[13] = '{1'b0, 6'd63, 8'h00, 8'h22};
        vecs[14] = '{1'b0, 6'd10, 8'h00, 8'h3C};

        post[0] = '{1'b0, 6'd5,  8'h00, 8'h00};
        post[1] = '{1'b0, 6'd63, 8'h00, 8'h00};
        post[2] = '{1'b0, 6'd0,  8'h00, 8'h00};
        post[3] = '{1'b1, 6'd20, 8'h5A, 8'h5A};
        post[4] = '{1'b0, 6'd10, 8'h00, 8'h00};

        #12;
        check("reset_hold", X, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

`ifndef RAM_REG_OUT_EN
        // Combinational read follows Addr with no clock edge.
        @(negedge clk);
        Addr = 6'd5;
        #1;
        check("comb_addr5", X, 8'hA5);
        Addr = 6'd0;
        #1;
        check("comb_addr0", X, 8'h11);
`endif

        // Reset pulse between edges while a write of 8'h77 to address 5 is pending.
        @(negedge clk);
        we   = 1'b1;
        Addr = 6'd5;
        Data = 8'h77;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_immediate", X, 8'h00);
        @(posedge clk);
        #1;
        check("rst_ignores_we", X, 8'h00);
        we = 1'b0;
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            apply($sformatf("post%0d", i), post[i]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
